// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles every handshake/bus signal of the two-requester line arbiter.
//   slave  : the arbiter's view (takes cache requests and memory
//            completions, drives cache acks/lines and the memory request).
//   master : the environment's view (I-cache, D-cache and memory model).
//   Signals:
//     ic_req_i/ic_addr_i, ic_ack_o/ic_line_o     I-cache refill port
//     dc_req_i/dc_we_i/dc_addr_i/dc_wline_i,
//     dc_ack_o/dc_line_o                          D-cache refill/writeback port
//     mem_req_o/mem_we_o/mem_addr_o/mem_wline_o,
//     mem_ack_i/mem_rline_i                       shared memory line port
interface mem_arbiter_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64
);
  localparam int LINE_BITS = LINE_BYTES * 8;

  logic                 ic_req_i;
  logic [ADDR_W-1:0]    ic_addr_i;
  logic                 ic_ack_o;
  logic [LINE_BITS-1:0] ic_line_o;

  logic                 dc_req_i;
  logic                 dc_we_i;
  logic [ADDR_W-1:0]    dc_addr_i;
  logic [LINE_BITS-1:0] dc_wline_i;
  logic                 dc_ack_o;
  logic [LINE_BITS-1:0] dc_line_o;

  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [LINE_BITS-1:0] mem_wline_o;
  logic                 mem_ack_i;
  logic [LINE_BITS-1:0] mem_rline_i;

  modport slave (
    input  ic_req_i, ic_addr_i,
    input  dc_req_i, dc_we_i, dc_addr_i, dc_wline_i,
    input  mem_ack_i, mem_rline_i,
    output ic_ack_o, ic_line_o,
    output dc_ack_o, dc_line_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wline_o
  );

  modport master (
    output ic_req_i, ic_addr_i,
    output dc_req_i, dc_we_i, dc_addr_i, dc_wline_i,
    output mem_ack_i, mem_rline_i,
    input  ic_ack_o, ic_line_o,
    input  dc_ack_o, dc_line_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wline_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single main-memory line port between the I-cache (refill
//   reads) and the D-cache (refills and writebacks). Whole-line transactions
//   are serialised; simultaneous requests alternate round-robin. Every
//   output comes straight from a register.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : mem_arbiter_if.slave (cache request/ack ports and memory port)
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(LINE_BYTES - 1);

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t               state;
  logic                 last_grant;
  logic                 mem_req_r;
  logic                 mem_we_r;
  logic [ADDR_W-1:0]    mem_addr_r;
  logic [LINE_BITS-1:0] mem_wline_r;
  logic                 ic_ack_r;
  logic                 dc_ack_r;
  logic [LINE_BITS-1:0] ic_line_r;
  logic [LINE_BITS-1:0] dc_line_r;

  function automatic logic [ADDR_W-1:0] align_line(input logic [ADDR_W-1:0] addr);
    return addr & ~OFS_MASK;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GRANT_D;  // first tie after reset goes to the I side
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wline_r <= '0;
      ic_ack_r    <= 1'b0;
      dc_ack_r    <= 1'b0;
      ic_line_r   <= '0;
      dc_line_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // I wins when alone, or on a tie when D had the previous grant.
          if (bus.ic_req_i && (!bus.dc_req_i || last_grant == GRANT_D)) begin
            last_grant  <= GRANT_I;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= align_line(bus.ic_addr_i);
            mem_wline_r <= '0;
            state       <= BUSY_I;
          end else if (bus.dc_req_i) begin
            last_grant  <= GRANT_D;
            mem_req_r   <= 1'b1;
            mem_we_r    <= bus.dc_we_i;
            mem_addr_r  <= align_line(bus.dc_addr_i);
            mem_wline_r <= bus.dc_wline_i;
            state       <= BUSY_D;
          end
        end

        BUSY_I, BUSY_D: begin
          if (bus.mem_ack_i) begin
            mem_req_r <= 1'b0;
            state     <= RESP;
            if (state == BUSY_I) begin
              ic_ack_r  <= 1'b1;
              ic_line_r <= bus.mem_rline_i;
            end else begin
              dc_ack_r <= 1'b1;
              // a writeback returns no data, so the D line register keeps its value
              if (!mem_we_r) begin
                dc_line_r <= bus.mem_rline_i;
              end
            end
          end
        end

        RESP: begin
          // requests and stray memory acks are ignored here
          ic_ack_r <= 1'b0;
          dc_ack_r <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_o   = mem_req_r;
  assign bus.mem_we_o    = mem_we_r;
  assign bus.mem_addr_o  = mem_addr_r;
  assign bus.mem_wline_o = mem_wline_r;
  assign bus.ic_ack_o    = ic_ack_r;
  assign bus.dc_ack_o    = dc_ack_r;
  assign bus.ic_line_o   = ic_line_r;
  assign bus.dc_line_o   = dc_line_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: a stimulus process issues cache requests
//   and queues the expected memory transactions and responses; a monitor
//   pops and compares them whenever the DUT starts a memory request or
//   pulses an ack. A small memory model acks after a programmable delay.
module tb_mem_arbiter;
  localparam int AW    = 32;
  localparam int LB    = 64;
  localparam int LBITS = LB * 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_BYTES(LB)) bus ();

  mem_arbiter #(.ADDR_W(AW), .LINE_BYTES(LB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic             we;
    logic [AW-1:0]    addr;
    logic [LBITS-1:0] wline;
  } mtx_t;

  typedef struct {
    logic             dside;
    logic [LBITS-1:0] ic_line;
    logic [LBITS-1:0] dc_line;
  } rsp_t;

  mtx_t mq[$];
  rsp_t rq[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [LBITS-1:0] sh_ic = '0;
  logic [LBITS-1:0] sh_dc = '0;

  // memory model state
  int               mem_wait    = 0;
  int               mcnt        = 0;
  logic             model_ack   = 1'b0;
  logic [LBITS-1:0] model_rline = '0;
  logic             stray       = 1'b0;

  localparam logic [LBITS-1:0] PAT_A5 = {64{8'hA5}};
  localparam logic [LBITS-1:0] PAT_3C = {64{8'h3C}};

  function automatic logic [LBITS-1:0] rline_of(input logic [AW-1:0] a);
    logic [LBITS-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = a ^ (32'h1111_1111 * 32'(i));
    return r;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [LBITS-1:0] act,
                            input logic [LBITS-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [AW-1:0] addr,
                         input logic [LBITS-1:0] wline);
    mtx_t m;
    m.we = we; m.addr = addr; m.wline = wline;
    mq.push_back(m);
  endtask

  task automatic exp_rsp(input logic dside);
    rsp_t r;
    r.dside = dside; r.ic_line = sh_ic; r.dc_line = sh_dc;
    rq.push_back(r);
  endtask

  task automatic wait_ack(input logic dside, input int exp_lat, input string name);
    int n = 0;
    bit seen = 0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      if (dside ? bus.dc_ack_o : bus.ic_ack_o) seen = 1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no ack within 60 cycles", name);
    end else begin
      check_int(name, n, exp_lat);
    end
    if (dside) bus.dc_req_i = 1'b0;
    else       bus.ic_req_i = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sh_ic = '0;
    sh_dc = '0;
  endtask

  assign bus.mem_ack_i   = model_ack | stray;
  assign bus.mem_rline_i = stray ? {16{32'hBAD0_BAD0}} : model_rline;

  // memory model: ack in the (mem_wait+1)-th cycle of a held request
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !bus.mem_req_o) begin
        model_ack = 1'b0;
        mcnt      = 0;
      end else begin
        model_ack = (mcnt == mem_wait);
        mcnt++;
      end
      model_rline = rline_of(bus.mem_addr_o);
    end
  end

  // monitor
  initial begin
    logic prev_req = 1'b0;
    logic prev_ack = 1'b0;
    mtx_t m;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (bus.mem_req_o && !prev_req) begin
          if (mq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_mem_req: addr %0h with none expected", bus.mem_addr_o);
          end else begin
            m = mq.pop_front();
            check_int("mem_we", int'(bus.mem_we_o), int'(m.we));
            check_int("mem_addr", int'(bus.mem_addr_o), int'(m.addr));
            check_line("mem_wline", bus.mem_wline_o, m.wline);
          end
        end
        if (bus.ic_ack_o || bus.dc_ack_o) begin
          check_int("ack_single_cycle", int'(prev_ack), 0);
          if (rq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ack: ic_ack=%0b dc_ack=%0b with none expected",
                     bus.ic_ack_o, bus.dc_ack_o);
          end else begin
            r = rq.pop_front();
            check_int("ack_side", int'({bus.ic_ack_o, bus.dc_ack_o}), r.dside ? 1 : 2);
            check_line("ic_line", bus.ic_line_o, r.ic_line);
            check_line("dc_line", bus.dc_line_o, r.dc_line);
          end
        end
        prev_req = bus.mem_req_o;
        prev_ack = bus.ic_ack_o | bus.dc_ack_o;
      end
    end
  end

  // stimulus
  initial begin
    bus.ic_req_i   = 1'b0;
    bus.ic_addr_i  = '0;
    bus.dc_req_i   = 1'b0;
    bus.dc_we_i    = 1'b0;
    bus.dc_addr_i  = '0;
    bus.dc_wline_i = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_int("rst_mem_req", int'(bus.mem_req_o), 0);
    check_int("rst_ic_ack", int'(bus.ic_ack_o), 0);
    check_int("rst_dc_ack", int'(bus.dc_ack_o), 0);
    check_int("rst_mem_addr", int'(bus.mem_addr_o), 0);
    check_line("rst_ic_line", bus.ic_line_o, '0);
    check_line("rst_dc_line", bus.dc_line_o, '0);
    rst = 1'b0;

    // single I read, zero-wait memory
    mem_wait = 0;
    exp_mem(1'b0, 32'h0000_1040, '0);
    sh_ic = rline_of(32'h0000_1040);
    exp_rsp(1'b0);
    @(negedge clk);
    bus.ic_addr_i = 32'h0000_1044;
    bus.ic_req_i  = 1'b1;
    wait_ack(1'b0, 2, "i_read_latency");

    // D write, four wait cycles
    mem_wait = 4;
    exp_mem(1'b1, 32'h0000_2000, PAT_A5);
    exp_rsp(1'b1);
    @(negedge clk);
    bus.dc_we_i    = 1'b1;
    bus.dc_addr_i  = 32'h0000_2000;
    bus.dc_wline_i = PAT_A5;
    bus.dc_req_i   = 1'b1;
    wait_ack(1'b1, 6, "d_write_latency");

    // D read, one wait cycle
    mem_wait = 1;
    exp_mem(1'b0, 32'h0000_3000, '0);
    sh_dc = rline_of(32'h0000_3000);
    exp_rsp(1'b1);
    @(negedge clk);
    bus.dc_we_i    = 1'b0;
    bus.dc_addr_i  = 32'h0000_3010;
    bus.dc_wline_i = '0;
    bus.dc_req_i   = 1'b1;
    wait_ack(1'b1, 3, "d_read_latency");

    // tie out of reset: grant order I, D, I
    pulse_reset();
    mem_wait = 0;
    exp_mem(1'b0, 32'h0000_4000, '0);
    sh_ic = rline_of(32'h0000_4000);
    exp_rsp(1'b0);
    exp_mem(1'b0, 32'h0000_5000, '0);
    sh_dc = rline_of(32'h0000_5000);
    exp_rsp(1'b1);
    exp_mem(1'b0, 32'h0000_6000, '0);
    sh_ic = rline_of(32'h0000_6000);
    exp_rsp(1'b0);
    bus.ic_addr_i = 32'h0000_4000;
    bus.ic_req_i  = 1'b1;
    bus.dc_we_i   = 1'b0;
    bus.dc_addr_i = 32'h0000_5000;
    bus.dc_req_i  = 1'b1;
    fork
      begin
        wait_ack(1'b0, 2, "tie_first_i");
        bus.ic_addr_i = 32'h0000_6000;
        bus.ic_req_i  = 1'b1;
        wait_ack(1'b0, 6, "tie_third_i");
      end
      wait_ack(1'b1, 5, "tie_second_d");
    join

    // contention: D arrives while I is busy
    @(negedge clk);
    mem_wait = 0;
    exp_mem(1'b0, 32'h0000_7000, '0);
    sh_ic = rline_of(32'h0000_7000);
    exp_rsp(1'b0);
    exp_mem(1'b1, 32'h0000_8000, PAT_3C);
    exp_rsp(1'b1);
    bus.ic_addr_i = 32'h0000_7000;
    bus.ic_req_i  = 1'b1;
    fork
      wait_ack(1'b0, 2, "cont_i");
      begin
        @(negedge clk);
        bus.dc_we_i    = 1'b1;
        bus.dc_addr_i  = 32'h0000_8000;
        bus.dc_wline_i = PAT_3C;
        bus.dc_req_i   = 1'b1;
        wait_ack(1'b1, 4, "cont_d_wait");
      end
      begin
        logic [4:0] pat;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          pat[4-k] = bus.mem_req_o;
        end
        check_int("cont_req_gap", int'(pat), 5'b10010);
      end
    join

    // stray mem_ack_i in IDLE
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    check_int("stray_idle_no_req", int'(bus.mem_req_o), 0);
    check_line("stray_idle_ic_line", bus.ic_line_o, sh_ic);
    check_line("stray_idle_dc_line", bus.dc_line_o, sh_dc);

    // stray mem_ack_i in RESP after a D read
    mem_wait = 0;
    exp_mem(1'b0, 32'h0000_9000, '0);
    sh_dc = rline_of(32'h0000_9000);
    exp_rsp(1'b1);
    bus.dc_we_i    = 1'b0;
    bus.dc_addr_i  = 32'h0000_9000;
    bus.dc_wline_i = '0;
    bus.dc_req_i   = 1'b1;
    fork
      wait_ack(1'b1, 2, "stray_resp_d");
      begin
        repeat (2) @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    check_line("stray_resp_ic_line", bus.ic_line_o, sh_ic);
    check_line("stray_resp_dc_line", bus.dc_line_o, sh_dc);

    // reset in the middle of a D write
    mem_wait = 30;
    exp_mem(1'b1, 32'h0000_A000, PAT_A5);
    bus.dc_we_i    = 1'b1;
    bus.dc_addr_i  = 32'h0000_A000;
    bus.dc_wline_i = PAT_A5;
    bus.dc_req_i   = 1'b1;
    repeat (3) @(negedge clk);
    check_int("busy_d_mem_req", int'(bus.mem_req_o), 1);
    check_int("busy_d_mem_we", int'(bus.mem_we_o), 1);
    #2 rst = 1'b1;
    #1;
    check_int("async_rst_mem_req", int'(bus.mem_req_o), 0);
    check_int("async_rst_mem_we", int'(bus.mem_we_o), 0);
    check_int("async_rst_mem_addr", int'(bus.mem_addr_o), 0);
    check_line("async_rst_mem_wline", bus.mem_wline_o, '0);
    check_int("async_rst_acks", int'({bus.ic_ack_o, bus.dc_ack_o}), 0);
    check_line("async_rst_ic_line", bus.ic_line_o, '0);
    check_line("async_rst_dc_line", bus.dc_line_o, '0);
    bus.dc_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sh_ic = '0;
    sh_dc = '0;

    // fresh I read after reset
    mem_wait = 0;
    exp_mem(1'b0, 32'h0000_B0C0, '0);
    sh_ic = rline_of(32'h0000_B0C0);
    exp_rsp(1'b0);
    @(negedge clk);
    bus.ic_addr_i = 32'h0000_B0C4;
    bus.ic_req_i  = 1'b1;
    wait_ack(1'b0, 2, "post_rst_i_read");

    repeat (3) @(negedge clk);
    check_int("mem_queue_drained", mq.size(), 0);
    check_int("rsp_queue_drained", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single main-memory line port between the instruction cache (refill reads only) and the data cache (refills and writebacks). It sits between the two cache controllers and the memory model/bus, serialises whole-line transactions, and returns each response to the requester that issued it. Fairness is round-robin on simultaneous requests.

## Interface
- ADDR_W, default ADDR_SIZE (32): byte address width.
- LINE_BYTES, default CACHE_LINE_SIZE (64): cache line size in bytes; power of two. LINE_BITS = LINE_BYTES*8 and OFS = log2(LINE_BYTES) are derived.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ic_req_i  in  1  I-cache line read request; held with ic_addr_i stable until ic_ack_o.
- ic_addr_i  in  ADDR_W  I-cache byte address.
- ic_ack_o  out  1  one-cycle completion pulse to I-cache.
- ic_line_o  out  LINE_BITS  registered read line for I-cache.
- dc_req_i  in  1  D-cache request; held with dc_we_i, dc_addr_i and dc_wline_i stable until dc_ack_o.
- dc_we_i  in  1  RD (0) = line read, WR (1) = line write.
- dc_addr_i  in  ADDR_W  D-cache byte address.
- dc_wline_i  in  LINE_BITS  write data for WR.
- dc_ack_o  out  1  one-cycle completion pulse to D-cache.
- dc_line_o  out  LINE_BITS  registered read line for D-cache.
- mem_req_o  out  1  memory transaction valid; held until mem_ack_i.
- mem_we_o  out  1  RD/WR of current transaction.
- mem_addr_o  out  ADDR_W  line-aligned address (low OFS bits zero).
- mem_wline_o  out  LINE_BITS  write data of current transaction.
- mem_ack_i  in  1  memory completion; meaningful only while mem_req_o = 1.
- mem_rline_i  in  LINE_BITS  read line, valid in the mem_ack_i cycle.

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: sample requests. Only ic_req_i set: go BUSY_I. Only dc_req_i set: go BUSY_D. Both set: grant the side not granted last (last_grant register); write last_grant on every grant.
- On grant, latch owner, address with low OFS bits forced to 0, we (I side always RD), and wline (I side: zero) into registers driving mem_*_o. mem_req_o = 1 in BUSY_I/BUSY_D only.
- BUSY_x: wait for mem_ack_i. On mem_ack_i with RD, load mem_rline_i into the owner's line register; the other line register is unchanged. With WR, no line register changes. Then go RESP.
- RESP: pulse owner's ack_o for exactly one cycle, then IDLE. Requests are never sampled in RESP.
- Requester drops req_i at the edge it sees ack_o (or holds it for a new, independent transaction that re-arbitrates in IDLE).
- A request arriving while the other side is being served waits; no preemption, no queue beyond the single held request per side.
- mem_ack_i in IDLE or RESP is ignored.
- Reset (asynchronous, any state, including mid-transaction): state IDLE; mem_req_o, mem_we_o, ic_ack_o, dc_ack_o = 0; mem_addr_o, mem_wline_o, ic_line_o, dc_line_o = 0; last_grant = D (so first tie goes to I). Outstanding memory transaction is abandoned; memory shares rst.

## Timing
- All outputs registered or decoded from registered state; no combinational path from any input to any output.
- Request seen in IDLE at cycle 0 -> mem_req_o high from cycle 1.
- Memory may ack in cycle 1 at the earliest. Ack in cycle k -> line register updated and ack_o high in cycle k+1 (RESP), mem_req_o low in cycle k+1, IDLE in cycle k+2.
- Minimum 3 cycles per transaction; back-to-back grants of alternating sides with zero-wait memory: one ack_o every 3 cycles.
- Line output holds its value until the next read for that side completes.

## Test plan
- Single I read: ic_req_i, ic_addr_i = 0x0000_1044, memory acks 1st cycle -> mem_addr_o = 0x0000_1040, mem_we_o = 0, ic_ack_o pulse in cycle 2 with ic_line_o = mem_rline_i; dc_line_o unchanged.
- D write: dc_we_i = 1, addr 0x0000_2000, wline pattern 0xA5.., memory acks after 4 wait cycles -> mem_we_o = 1, mem_wline_o = pattern, dc_ack_o 1 cycle after mem_ack_i, dc_line_o unchanged.
- Tie out of reset: both requests in cycle 0 held -> I served first, then D, then (I re-requesting) I again; grant order I, D, I.
- Contention: D request while BUSY_I -> D waits, mem_req_o deasserts for exactly one RESP cycle plus one IDLE cycle before D's mem_req_o.
- Stray mem_ack_i in IDLE and RESP -> no ack_o, no line register change.
- rst asserted mid BUSY_D -> all outputs 0 immediately (async); after release, a fresh I request completes normally.
